io_write_arbiter: RTL and testbench
===================================

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each per-requester write counter.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 makes requester 0 always win.
REQ-003 io_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 clr  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  write request from requester 0 (CPU store path) / requester 1 (secondary master).
REQ-006 addr0 / addr1  input  32  byte address of the requested IO write.
REQ-007 data0 / data1  input  32  write data.
REQ-008 ack0 / ack1  output  1  one-cycle pulse: write performed for that requester.
REQ-009 err0 / err1  output  1  one-cycle pulse: request rejected, invalid address.
REQ-010 io_addr  output  32  address driven to the IO output register bank.
REQ-011 io_data  output  32  data driven to the IO output register bank.
REQ-012 write_io_enable  output  1  write strobe to the IO output register bank.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 wr_cnt0 / wr_cnt1  output  CNT_W  count of successful writes per requester.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WRITE and REJECT; WRITE and REJECT SHALL each last exactly one cycle and SHALL return to IDLE unconditionally.
REQ-016 req0/req1 SHALL be sampled only in IDLE; with no request asserted, the FSM SHALL stay in IDLE.
REQ-017 With one request asserted in IDLE, that requester SHALL win; with both asserted: FIXED_PRIO=1 -> requester 0 wins; FIXED_PRIO=0 -> the requester not granted last wins.
REQ-018 The last-grant pointer SHALL update on every WRITE and every REJECT entry.
REQ-019 A winner address SHALL be valid iff addr[7:2] is one of 6'h20, 6'h21 or 6'h22; all other address bits SHALL be ignored.
REQ-020 A valid winner SHALL cause: next state WRITE, io_addr/io_data registered from the winner's inputs on the same edge.
REQ-021 An invalid winner SHALL cause: next state REJECT, with io_addr/io_data unchanged.
REQ-022 In WRITE: write_io_enable=1 and the winner's ack=1; in REJECT: the winner's err=1 and write_io_enable=0.
REQ-023 Latency: a request sampled in IDLE at edge N SHALL produce the strobe/ack (or err) in the cycle following edge N; peak throughput is one write per 2 cycles.
REQ-024 A requester SHALL hold req, addr and data stable until its ack or err; after ack/err it SHALL drop req or present a new transfer.
REQ-025 A request re-asserted in the IDLE cycle after ack SHALL be treated as a new transfer.
REQ-026 A request withdrawn before it is sampled in IDLE SHALL produce no transaction.
REQ-027 io_addr/io_data SHALL hold their last written values outside WRITE.
REQ-028 The counter wr_cntK SHALL increment by 1 on each WRITE owned by requester K and SHALL saturate at all-ones; REJECT SHALL NOT count.
REQ-029 ack and err for the same requester SHALL never be high together; at most one of ack0/ack1/err0/err1 SHALL be high in any cycle.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any req input.

Reset
REQ-031 clr=1 SHALL immediately force: state IDLE, write_io_enable=0, all ack/err=0, busy=0, io_addr=0, io_data=0, wr_cnt0=wr_cnt1=0, and the last-grant pointer to "requester 1", so that requester 0 wins the first tie.
REQ-032 Asserting clr during WRITE or REJECT SHALL abort the transfer with no ack/err; the requester retries after clr deasserts.
REQ-033 The first request sampling after clr deasserts SHALL occur at the first rising edge with clr=0.

Structure
REQ-034 Package io_arb_pkg SHALL hold the state encoding (IDLE/WRITE/REJECT) and the port-index constants 6'h20, 6'h21 and 6'h22.
REQ-035 The 2-way round-robin/fixed-priority picker SHALL be a sub-module io_rr_pick2, with inputs req[1:0], last, fixed and output a one-hot grant.

Verification
REQ-036 After reset: req0=1, addr0=0x80, data0=0x1234 -> next cycle write_io_enable=1, io_addr=0x80, io_data=0x1234, ack0=1; wr_cnt0=1.
REQ-037 req0 and req1 held continuously with valid addresses 0x84/0x88 -> grants alternate 0,1,0,1 on every other cycle; requester 0 goes first.
REQ-038 req1=1, addr1=0x40 -> err1 pulse one cycle later, write_io_enable stays 0, io_addr unchanged, wr_cnt1 unchanged.
REQ-039 FIXED_PRIO=1, both requests held -> only requester 0 is granted; requester 1 is granted on the first IDLE cycle after req0 drops.
REQ-040 clr pulsed during WRITE -> write_io_enable and ack fall immediately, counters read 0; the held request completes after release.
REQ-041 Preload wr_cnt0 near saturation by forcing 2^CNT_W-1 writes (or a CNT_W=4 build) -> wr_cnt0 stays at all-ones thereafter.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the IO write arbiter: FSM encoding,
// valid IO port indices and the address-decode helper.
package io_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_REJECT = 2'd2
    } arb_state_e;

    localparam logic [5:0] PORT_IDX_0 = 6'h20;
    localparam logic [5:0] PORT_IDX_1 = 6'h21;
    localparam logic [5:0] PORT_IDX_2 = 6'h22;

    // Only the word index addr[7:2] selects an IO port; other bits are don't-care.
    function automatic logic addr_valid(input logic [31:0] addr);
        logic [5:0] idx;
        idx        = addr[7:2];
        addr_valid = (idx == PORT_IDX_0) || (idx == PORT_IDX_1) || (idx == PORT_IDX_2);
    endfunction

endpackage

// File: rtl/io_rr_pick2.sv
// Two-way picker: round-robin on the last grant, or requester 0 always
// wins when fixed is set. Grant is one-hot, or zero when nothing requests.
module io_rr_pick2
    import io_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] grant
);

    logic [1:0] grant_s;

    // Select the winner; on a tie, last=1 (requester 1 served last) favours requester 0.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01: grant_s = 2'b01;
            2'b10: grant_s = 2'b10;
            2'b11: begin
                if (fixed || last) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b10;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

endmodule

// File: rtl/io_write_arbiter.sv
// Arbitrates two IO write requesters onto one IO output register bank,
// rejecting writes whose word index is not a known IO port.
module io_write_arbiter
    import io_arb_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             io_clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [31:0]      addr0,
    input  logic [31:0]      addr1,
    input  logic [31:0]      data0,
    input  logic [31:0]      data1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [31:0]      io_addr,
    output logic [31:0]      io_data,
    output logic             write_io_enable,
    output logic             busy,
    output logic [CNT_W-1:0] wr_cnt0,
    output logic [CNT_W-1:0] wr_cnt1
);

    localparam logic FIXED_S = (FIXED_PRIO != 0);

    arb_state_e       state_r;
    logic             last_r;
    logic             ack0_r;
    logic             ack1_r;
    logic             err0_r;
    logic             err1_r;
    logic             we_r;
    logic [31:0]      io_addr_r;
    logic [31:0]      io_data_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    logic [1:0]       grant_s;
    logic [31:0]      win_addr_s;
    logic [31:0]      win_data_s;
    logic             valid_s;
    logic             inc0_s;
    logic             inc1_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    io_rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_r),
        .fixed (FIXED_S),
        .grant (grant_s)
    );

    // Route the winning requester's address/data and decode its validity.
    always_comb begin
        win_addr_s = addr0;
        win_data_s = data0;
        if (grant_s[1]) begin
            win_addr_s = addr1;
            win_data_s = data1;
        end else begin
            win_addr_s = addr0;
            win_data_s = data0;
        end
        valid_s = addr_valid(win_addr_s);
        inc0_s  = (state_r == ST_IDLE) && grant_s[0] && valid_s;
        inc1_s  = (state_r == ST_IDLE) && grant_s[1] && valid_s;
    end

    // Arbitration FSM with registered strobes and IO bank address/data.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b1;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            we_r      <= 1'b0;
            io_addr_r <= 32'h0000_0000;
            io_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        last_r <= grant_s[1];
                        if (valid_s) begin
                            state_r   <= ST_WRITE;
                            io_addr_r <= win_addr_s;
                            io_data_r <= win_data_s;
                            we_r      <= 1'b1;
                            ack0_r    <= grant_s[0];
                            ack1_r    <= grant_s[1];
                        end else begin
                            state_r <= ST_REJECT;
                            err0_r  <= grant_s[0];
                            err1_r  <= grant_s[1];
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    // WRITE and REJECT are single-cycle and always fall back to IDLE.
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                    ack0_r  <= 1'b0;
                    ack1_r  <= 1'b0;
                    err0_r  <= 1'b0;
                    err1_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-requester write counters, bumped on entry to WRITE.
    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (inc0_s) begin
                cnt0_r <= sat_inc(cnt0_r);
            end
            if (inc1_s) begin
                cnt1_r <= sat_inc(cnt1_r);
            end
        end
    end

    assign ack0            = ack0_r;
    assign ack1            = ack1_r;
    assign err0            = err0_r;
    assign err1            = err1_r;
    assign write_io_enable = we_r;
    assign io_addr         = io_addr_r;
    assign io_data         = io_data_r;
    assign busy            = (state_r != ST_IDLE);
    assign wr_cnt0         = cnt0_r;
    assign wr_cnt1         = cnt1_r;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench: instance A is round-robin with 16-bit counters, instance B
// is fixed-priority with 4-bit counters; both see the same stimulus.
module tb_io_write_arbiter;

    logic        io_clk;
    logic        clr;
    logic        req0, req1;
    logic [31:0] addr0, addr1, data0, data1;

    logic        a_ack0, a_ack1, a_err0, a_err1, a_we, a_busy;
    logic [31:0] a_io_addr, a_io_data;
    logic [15:0] a_cnt0, a_cnt1;
    logic        b_ack0, b_ack1, b_err0, b_err1, b_we, b_busy;
    logic [31:0] b_io_addr, b_io_data;
    logic [3:0]  b_cnt0, b_cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    io_write_arbiter #(.CNT_W(16), .FIXED_PRIO(0)) dut_a (
        .io_clk(io_clk), .clr(clr),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .ack0(a_ack0), .ack1(a_ack1), .err0(a_err0), .err1(a_err1),
        .io_addr(a_io_addr), .io_data(a_io_data),
        .write_io_enable(a_we), .busy(a_busy),
        .wr_cnt0(a_cnt0), .wr_cnt1(a_cnt1)
    );

    io_write_arbiter #(.CNT_W(4), .FIXED_PRIO(1)) dut_b (
        .io_clk(io_clk), .clr(clr),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .ack0(b_ack0), .ack1(b_ack1), .err0(b_err0), .err1(b_err1),
        .io_addr(b_io_addr), .io_data(b_io_data),
        .write_io_enable(b_we), .busy(b_busy),
        .wr_cnt0(b_cnt0), .wr_cnt1(b_cnt1)
    );

    // Free-running 10 ns clock.
    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        clr   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = 32'h0;
        addr1 = 32'h0;
        data0 = 32'h0;
        data1 = 32'h0;
        #1;
        chk("rst_we",    32'(a_we),      32'd0);
        chk("rst_busy",  32'(a_busy),    32'd0);
        chk("rst_addr",  a_io_addr,      32'h0);
        chk("rst_data",  a_io_data,      32'h0);
        chk("rst_cnt0",  32'(a_cnt0),    32'd0);
        chk("rst_ack",   32'({a_ack0, a_ack1, a_err0, a_err1}), 32'd0);
        tick();
        clr = 1'b0;

        // First write after reset.
        req0 = 1'b1; addr0 = 32'h80; data0 = 32'h1234;
        tick();
        chk("w1_we",   32'(a_we),    32'd1);
        chk("w1_ack0", 32'(a_ack0),  32'd1);
        chk("w1_ack1", 32'(a_ack1),  32'd0);
        chk("w1_addr", a_io_addr,    32'h80);
        chk("w1_data", a_io_data,    32'h1234);
        chk("w1_cnt0", 32'(a_cnt0),  32'd1);
        chk("w1_busy", 32'(a_busy),  32'd1);
        chk("w1_bcnt", 32'(b_cnt0),  32'd1);
        req0 = 1'b0;
        tick();
        chk("w1_idle_we",   32'(a_we),   32'd0);
        chk("w1_idle_ack",  32'(a_ack0), 32'd0);
        chk("w1_idle_busy", 32'(a_busy), 32'd0);
        chk("w1_hold_addr", a_io_addr,   32'h80);

        // Invalid address is rejected without touching the bank.
        req1 = 1'b1; addr1 = 32'h40; data1 = 32'hdead;
        tick();
        chk("rej_err1", 32'(a_err1), 32'd1);
        chk("rej_ack1", 32'(a_ack1), 32'd0);
        chk("rej_we",   32'(a_we),   32'd0);
        chk("rej_addr", a_io_addr,   32'h80);
        chk("rej_data", a_io_data,   32'h1234);
        chk("rej_cnt1", 32'(a_cnt1), 32'd0);
        chk("rej_busy", 32'(a_busy), 32'd1);
        req1 = 1'b0;
        tick();
        chk("rej_end", 32'(a_err1), 32'd0);

        // A request withdrawn before its sampling edge yields nothing.
        req1 = 1'b1; addr1 = 32'h84;
        #2;
        req1 = 1'b0;
        tick();
        chk("wd_busy", 32'(a_busy), 32'd0);
        chk("wd_ack1", 32'(a_ack1), 32'd0);
        chk("wd_cnt1", 32'(a_cnt1), 32'd0);

        // Both requesters held: A alternates starting with 0, B always grants 0.
        req0 = 1'b1; addr0 = 32'h84; data0 = 32'ha0;
        req1 = 1'b1; addr1 = 32'h88; data1 = 32'hb1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_ack0", 32'(a_ack0), i[0] ? 32'd0 : 32'd1);
            chk("rr_ack1", 32'(a_ack1), i[0] ? 32'd1 : 32'd0);
            chk("rr_addr", a_io_addr,   i[0] ? 32'h88 : 32'h84);
            chk("rr_data", a_io_data,   i[0] ? 32'hb1 : 32'ha0);
            chk("fx_ack0", 32'(b_ack0), 32'd1);
            chk("fx_ack1", 32'(b_ack1), 32'd0);
            tick();
            chk("rr_gap_we", 32'(a_we), 32'd0);
        end
        chk("rr_cnt0", 32'(a_cnt0), 32'd3);
        chk("rr_cnt1", 32'(a_cnt1), 32'd2);
        chk("fx_cnt0", 32'(b_cnt0), 32'd5);
        chk("fx_cnt1", 32'(b_cnt1), 32'd0);
        req0 = 1'b0;
        tick();
        chk("fx_late_ack1", 32'(b_ack1), 32'd1);
        chk("fx_late_addr", b_io_addr,   32'h88);
        chk("rr_solo_ack1", 32'(a_ack1), 32'd1);
        chk("fx_late_cnt1", 32'(b_cnt1), 32'd1);
        req1 = 1'b0;
        tick();

        // Upper address bits are ignored by the port decode.
        req0 = 1'b1; addr0 = 32'h1234_5681; data0 = 32'h00c0_ffee;
        tick();
        chk("hi_ack0", 32'(a_ack0), 32'd1);
        chk("hi_addr", a_io_addr,   32'h1234_5681);
        chk("hi_cnt0", 32'(a_cnt0), 32'd4);
        req0 = 1'b0;
        tick();

        // Reset during WRITE aborts it; the held request completes afterwards.
        req0 = 1'b1; addr0 = 32'h84; data0 = 32'h55;
        tick();
        chk("clr_pre_we", 32'(a_we), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr_we",   32'(a_we),   32'd0);
        chk("clr_ack0", 32'(a_ack0), 32'd0);
        chk("clr_cnt0", 32'(a_cnt0), 32'd0);
        chk("clr_addr", a_io_addr,   32'h0);
        chk("clr_busy", 32'(a_busy), 32'd0);
        chk("clr_bcnt", 32'(b_cnt0), 32'd0);
        clr = 1'b0;
        tick();
        chk("retry_we",   32'(a_we),   32'd1);
        chk("retry_ack0", 32'(a_ack0), 32'd1);
        chk("retry_addr", a_io_addr,   32'h84);
        chk("retry_data", a_io_data,   32'h55);
        chk("retry_cnt0", 32'(a_cnt0), 32'd1);

        // Keep req0 high: 16 more writes saturate B's 4-bit counter.
        for (int i = 0; i < 32; i++) begin
            tick();
        end
        chk("sat_ack0", 32'(b_ack0), 32'd1);
        chk("sat_bcnt", 32'(b_cnt0), 32'hf);
        chk("sat_acnt", 32'(a_cnt0), 32'd17);
        tick();
        tick();
        chk("sat_hold", 32'(b_cnt0), 32'hf);
        chk("sat_acnt2", 32'(a_cnt0), 32'd18);
        req0 = 1'b0;
        tick();
        chk("end_busy", 32'(a_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
